// File: rtl/muldiv_pkg.sv
// Shared op codes and decode helper for the EX-stage multiply/divide unit.
// Optional madd family is enabled by defining MULDIV_MADD_EN.
package muldiv_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {S_IDLE, S_BUSY} muldiv_state_e;

  // True for ops that take a multi-cycle busy period (the hazard unit stalls on these).
  function automatic logic is_muldiv(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_muldiv = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_muldiv = 1'b1;
`endif
      default: is_muldiv = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational result datapath: next {hi,lo} from latched op/operands and current HI/LO.
// Madd-family arithmetic is compiled in only with MULDIV_MADD_EN.
module muldiv_calc
  import muldiv_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_next
);

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic        [31:0] w_abs_a;
  logic        [31:0] w_abs_b;
  logic        [31:0] w_mag_q;
  logic        [31:0] w_mag_r;
  logic        [31:0] w_squot;
  logic        [31:0] w_srem;
  logic        [31:0] w_uquot;
  logic        [31:0] w_urem;
  logic               w_div0;

  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  // Signed divide via magnitudes; 0x80000000/-1 falls out as lo=0x80000000, hi=0.
  assign w_abs_a = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_abs_b = i_b[31] ? (32'd0 - i_b) : i_b;
  assign w_mag_q = w_abs_a / w_abs_b;
  assign w_mag_r = w_abs_a % w_abs_b;
  assign w_squot = (i_a[31] ^ i_b[31]) ? (32'd0 - w_mag_q) : w_mag_q;
  assign w_srem  = i_a[31] ? (32'd0 - w_mag_r) : w_mag_r;
  assign w_uquot = i_a / i_b;
  assign w_urem  = i_a % i_b;
  assign w_div0  = (i_b == 32'd0);

  always_comb begin
    o_next = {i_hi, i_lo};
    case (i_op)
      OP_MULT:  o_next = w_sprod;
      OP_MULTU: o_next = w_uprod;
      OP_DIV: begin
        if (w_div0) o_next = {i_hi, i_lo};
        else        o_next = {w_srem, w_squot};
      end
      OP_DIVU: begin
        if (w_div0) o_next = {i_hi, i_lo};
        else        o_next = {w_urem, w_uquot};
      end
`ifdef MULDIV_MADD_EN
      OP_MADD:  o_next = {i_hi, i_lo} + w_sprod;
      OP_MADDU: o_next = {i_hi, i_lo} + w_uprod;
      OP_MSUB:  o_next = {i_hi, i_lo} - w_sprod;
      OP_MSUBU: o_next = {i_hi, i_lo} - w_uprod;
`endif
      default:  o_next = {i_hi, i_lo};
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: latency counter, IDLE/BUSY FSM and HI/LO registers.
// Define MULDIV_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  muldiv_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_busy;
  logic [CW-1:0] w_lat;
  logic [63:0]   w_next;

  assign w_lat = ((op == OP_DIV) || (op == OP_DIVU)) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

  muldiv_calc u_calc (
    .i_op   (r_op),
    .i_a    (r_a),
    .i_b    (r_b),
    .i_hi   (r_hi),
    .i_lo   (r_lo),
    .o_next (w_next)
  );

  // Accept in IDLE, count down in BUSY, write the result on the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_NONE;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && is_muldiv(op)) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= w_lat;
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
          end else if (start && (op == OP_MTHI)) begin
            r_hi <= a;
          end else if (start && (op == OP_MTLO)) begin
            r_lo <= a;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_BUSY: begin
          if (r_cnt == CW'(1)) begin
            {r_hi, r_lo} <= w_next;
            r_cnt        <= '0;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv; madd checks follow MULDIV_MADD_EN.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_err;
  int ncyc;

  ex_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one op for a single edge, then count busy cycles (bounded).
  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output int nc);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    nc = 0;
    while (busy === 1'b1 && nc < 200) begin
      nc++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; op = OP_NONE; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_vec("rst_busy", {31'd0, busy}, 32'd0);
    check_vec("rst_hi", hi, 32'd0);
    check_vec("rst_lo", lo, 32'd0);

    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, ncyc);
    check_vec("mult_cyc", ncyc, MC);
    check_vec("mult_hi", hi, 32'hFFFF_FFFF);
    check_vec("mult_lo", lo, 32'hFFFF_FFFE);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, ncyc);
    check_vec("multu_cyc", ncyc, MC);
    check_vec("multu_hi", hi, 32'h0000_0001);
    check_vec("multu_lo", lo, 32'hFFFF_FFFE);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, ncyc);
    check_vec("div_cyc", ncyc, DC);
    check_vec("div_hi", hi, 32'hFFFF_FFFF);
    check_vec("div_lo", lo, 32'hFFFF_FFFD);

    issue(OP_MTHI, 32'h0000_0011, 32'd0, ncyc);
    check_vec("mthi_cyc", ncyc, 0);
    check_vec("mthi_hi", hi, 32'h0000_0011);
    check_vec("mthi_lo_keep", lo, 32'hFFFF_FFFD);
    issue(OP_MTLO, 32'h0000_0022, 32'd0, ncyc);
    check_vec("mtlo_lo", lo, 32'h0000_0022);
    check_vec("mtlo_hi_keep", hi, 32'h0000_0011);

    issue(OP_DIVU, 32'd7, 32'd0, ncyc);
    check_vec("div0_cyc", ncyc, DC);
    check_vec("div0_hi", hi, 32'h0000_0011);
    check_vec("div0_lo", lo, 32'h0000_0022);

    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, ncyc);
    check_vec("divu_hi", hi, 32'h0000_0001);
    check_vec("divu_lo", lo, 32'h7FFF_FFFC);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ncyc);
    check_vec("ovf_cyc", ncyc, DC);
    check_vec("ovf_hi", hi, 32'h0000_0000);
    check_vec("ovf_lo", lo, 32'h8000_0000);

    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, ncyc);
    check_vec("divneg_hi", hi, 32'h0000_0001);
    check_vec("divneg_lo", lo, 32'hFFFF_FFFD);

    issue(OP_NONE, 32'h1234_5678, 32'd1, ncyc);
    check_vec("none_cyc", ncyc, 0);
    issue(4'hF, 32'h1234_5678, 32'd1, ncyc);
    check_vec("unk_cyc", ncyc, 0);
    check_vec("unk_hi", hi, 32'h0000_0001);
    check_vec("unk_lo", lo, 32'hFFFF_FFFD);

    // Reset lands on the third busy cycle of a DIV 100/7.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_vec("abort_busy", {31'd0, busy}, 32'd0);
    check_vec("abort_hi", hi, 32'd0);
    check_vec("abort_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    check_vec("abort_late_busy", {31'd0, busy}, 32'd0);
    check_vec("abort_late_hi", hi, 32'd0);
    check_vec("abort_late_lo", lo, 32'd0);

    // MULT 3*4 with stray starts injected mid-flight.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    ncyc = 0;
    while (busy === 1'b1 && ncyc < 200) begin
      ncyc++;
      if (ncyc == 2) begin
        $display("note: start asserted while busy (hazard violation injected)");
        start = 1'b1; op = OP_DIV; a = 32'h0000_DEAD; b = 32'd1;
      end else if (ncyc == 3) begin
        start = 1'b1; op = OP_MTHI; a = 32'h0000_BEEF; b = 32'd0;
      end else begin
        start = 1'b0; op = OP_NONE;
      end
      @(negedge clk);
    end
    start = 1'b0; op = OP_NONE;
    check_vec("ign_cyc", ncyc, MC);
    check_vec("ign_hi", hi, 32'd0);
    check_vec("ign_lo", lo, 32'd12);
    repeat (3) @(negedge clk);
    check_vec("ign_after_busy", {31'd0, busy}, 32'd0);

    issue(OP_MTHI, 32'd0, 32'd0, ncyc);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0, ncyc);
    issue(OP_MADDU, 32'd1, 32'd1, ncyc);
`ifdef MULDIV_MADD_EN
    check_vec("maddu_cyc", ncyc, MC);
    check_vec("maddu_hi", hi, 32'h0000_0001);
    check_vec("maddu_lo", lo, 32'h0000_0000);
    issue(OP_MSUB, 32'd1, 32'd1, ncyc);
    check_vec("msub_hi", hi, 32'h0000_0000);
    check_vec("msub_lo", lo, 32'hFFFF_FFFF);
`else
    check_vec("maddu_cyc", ncyc, 0);
    check_vec("maddu_hi", hi, 32'h0000_0000);
    check_vec("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
